// File: rtl/csr_pkg.sv
// csr_pkg: shared constants for the machine-mode CSR unit.
// Holds the CSR addresses, the Zicsr funct3 encodings, trap/interrupt cause
// codes, mstatus bit positions, write masks and the misa images.
package csr_pkg;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  // funct3 of the Zicsr instructions; bit 2 selects the zimm operand
  typedef enum logic [2:0] {
    OP_RW  = 3'b001,
    OP_RS  = 3'b010,
    OP_RC  = 3'b011,
    OP_RWI = 3'b101,
    OP_RSI = 3'b110,
    OP_RCI = 3'b111
  } csr_op_e;

  // Exception causes
  localparam logic [3:0] CAUSE_ILLEGAL_INSN = 4'd2;
  localparam logic [3:0] CAUSE_BREAKPOINT   = 4'd3;
  localparam logic [3:0] CAUSE_ECALL_M      = 4'd11;

  // Interrupt codes (also their bit positions in mie/mip)
  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  // mstatus fields
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam logic [63:0] MSTATUS_MPP_MASK = 64'h0000_0000_0000_1800;

  // Write masks
  localparam logic [63:0] MIE_WMASK   = 64'h0000_0000_0000_0888;
  localparam logic [63:0] MTVEC_WMASK = ~64'h2;
  localparam logic [63:0] MEPC_WMASK  = ~64'h3;

  // misa images: MXL plus the I and M extension bits
  localparam logic [63:0] MISA_RV64 = 64'h8000_0000_0000_1100;
  localparam logic [63:0] MISA_RV32 = 64'h0000_0000_4000_1100;

  // Read-only CSRs: the whole 0xC00-0xFFF block, plus mip
  function automatic logic csr_is_read_only(input logic [11:0] addr);
    return (addr[11:10] == 2'b11) || (addr == CSR_MIP);
  endfunction

endpackage

// File: rtl/csr_unit_if.sv
// csr_unit_if: pipeline <-> CSR unit signal bundle.
// Handshake: csr_valid qualifies csr_op/csr_addr/csr_rs1/csr_rs1data for one
// cycle; there is no ready, the CSR unit always accepts and answers in the
// same cycle (csr_rdata, redirect_valid/redirect_pc, trap_taken are
// combinational). ecall/ebreak/mret are single-cycle pulses qualified by pc.
// master: pipeline side.  slave: csr_unit side.
interface csr_unit_if #(
  parameter int XLEN = 64
);
  logic            csr_valid;
  logic [2:0]      csr_op;
  logic [11:0]     csr_addr;
  logic [4:0]      csr_rs1;
  logic [XLEN-1:0] csr_rs1data;
  logic [XLEN-1:0] csr_rdata;
  logic            ecall;
  logic            ebreak;
  logic            mret;
  logic [XLEN-1:0] pc;
  logic            irq_window;
  logic            retire;
  logic            meip;
  logic            msip;
  logic            mtip;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            trap_taken;

  modport master (
    output csr_valid, csr_op, csr_addr, csr_rs1, csr_rs1data,
    output ecall, ebreak, mret, pc, irq_window, retire, meip, msip, mtip,
    input  csr_rdata, redirect_valid, redirect_pc, trap_taken
  );

  modport slave (
    input  csr_valid, csr_op, csr_addr, csr_rs1, csr_rs1data,
    input  ecall, ebreak, mret, pc, irq_window, retire, meip, msip, mtip,
    output csr_rdata, redirect_valid, redirect_pc, trap_taken
  );
endinterface

// File: rtl/csr_counter.sv
// csr_counter: 64-bit free-running counter with a CSR write override.
// Ports: clk, rst (sync, active-high), inc_i (count enable), we_i/wdata_i
// (load, wins over the increment), count_o (current value). Wraps to 0.
module csr_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  input  logic        we_i,
  input  logic [63:0] wdata_i,
  output logic [63:0] count_o
);
  logic [63:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (we_i) begin
      count_d = wdata_i;
    end else if (inc_i) begin
      count_d = count_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
endmodule

// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file and trap controller.
// Ports: clk, rst (sync, active-high), bus (csr_unit_if.slave) carrying the
// Zicsr request, ecall/ebreak/mret, pc, irq_window, retire, interrupt lines
// and the combinational csr_rdata / redirect_valid / redirect_pc / trap_taken.
// Event priority inside a cycle: exception > mret > interrupt > CSR write.
module csr_unit
  import csr_pkg::*;
#(
  parameter int          XLEN          = 64,
  parameter logic [63:0] MSTATUS_RESET = 64'h0000_000a_0000_1800,
  parameter logic [63:0] MTVEC_RESET   = 64'h0,
  parameter logic [63:0] HARTID        = 64'h0,
  parameter bit          HAS_COUNTERS  = 1'b1
) (
  input logic       clk,
  input logic       rst,
  csr_unit_if.slave bus
);
  // mstatus bits other than MIE/MPIE are constant; MPP is always M-mode
  localparam logic [XLEN-1:0] MSTATUS_FIXED = XLEN'(MSTATUS_RESET | MSTATUS_MPP_MASK);
  localparam logic [XLEN-1:0] MISA_VAL = (XLEN == 64) ? XLEN'(MISA_RV64) : XLEN'(MISA_RV32);

  logic            mst_mie_q, mst_mie_d, mst_mpie_q, mst_mpie_d;
  logic [XLEN-1:0] mie_q, mie_d, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [63:0]     mcycle, minstret, cyc_wdata, ins_wdata;
  logic            cyc_we, ins_we;
  logic [XLEN-1:0] mstatus_val, mip_val, old_val, operand, new_val;
  logic [XLEN-1:0] irq_pend, tvec_base, exc_tval;
  logic [3:0]      exc_cause, irq_code;
  logic            addr_ok, op_ok, wr_req, illegal, exc, mret_ev, irq_ev, csr_wr;

  always_comb begin
    mstatus_val = MSTATUS_FIXED;
    mstatus_val[MSTATUS_MIE_BIT]  = mst_mie_q;
    mstatus_val[MSTATUS_MPIE_BIT] = mst_mpie_q;
    mip_val = '0;
    mip_val[IRQ_MEI] = bus.meip;
    mip_val[IRQ_MTI] = bus.mtip;
    mip_val[IRQ_MSI] = bus.msip;
  end

  // Read mux; also decides whether the address exists
  always_comb begin
    old_val = '0;
    addr_ok = 1'b1;
    case (bus.csr_addr)
      CSR_MSTATUS:            old_val = mstatus_val;
      CSR_MISA:               old_val = MISA_VAL;
      CSR_MIE:                old_val = mie_q;
      CSR_MTVEC:              old_val = mtvec_q;
      CSR_MSCRATCH:           old_val = mscratch_q;
      CSR_MEPC:               old_val = mepc_q;
      CSR_MCAUSE:             old_val = mcause_q;
      CSR_MTVAL:              old_val = mtval_q;
      CSR_MIP:                old_val = mip_val;
      CSR_MHARTID:            old_val = XLEN'(HARTID);
      CSR_MCYCLE, CSR_CYCLE: begin
        old_val = mcycle[XLEN-1:0];
        addr_ok = HAS_COUNTERS;
      end
      CSR_MINSTRET, CSR_INSTRET: begin
        old_val = minstret[XLEN-1:0];
        addr_ok = HAS_COUNTERS;
      end
      default:                addr_ok = 1'b0;
    endcase
  end

  // Operand and read-modify-write value
  always_comb begin
    operand = bus.csr_op[2] ? {{(XLEN-5){1'b0}}, bus.csr_rs1} : bus.csr_rs1data;
    new_val = old_val;
    op_ok   = 1'b1;
    case (bus.csr_op)
      OP_RW, OP_RWI: new_val = operand;
      OP_RS, OP_RSI: new_val = old_val | operand;
      OP_RC, OP_RCI: new_val = old_val & ~operand;
      default:       op_ok   = 1'b0;
    endcase
  end

  // Set/clear with rs1/zimm = 0 is a pure read and may target read-only CSRs
  assign wr_req  = (bus.csr_op[1:0] == 2'b01) || (bus.csr_rs1 != 5'd0);
  assign illegal = bus.csr_valid &&
                   (!addr_ok || !op_ok || (csr_is_read_only(bus.csr_addr) && wr_req));

  assign exc      = !rst && (illegal || bus.ecall || bus.ebreak);
  assign mret_ev  = !rst && !exc && bus.mret;
  assign irq_pend = mie_q & mip_val;
  assign irq_ev   = !rst && !exc && !bus.mret && bus.irq_window && mst_mie_q &&
                    (irq_pend != '0);
  assign csr_wr   = !rst && bus.csr_valid && wr_req && !exc && !bus.mret && !irq_ev;

  assign irq_code  = irq_pend[IRQ_MEI] ? IRQ_MEI : (irq_pend[IRQ_MSI] ? IRQ_MSI : IRQ_MTI);
  assign exc_cause = illegal ? CAUSE_ILLEGAL_INSN : (bus.ecall ? CAUSE_ECALL_M : CAUSE_BREAKPOINT);
  assign exc_tval  = illegal ? {{(XLEN-12){1'b0}}, bus.csr_addr} :
                     (bus.ecall ? '0 : bus.pc);
  assign tvec_base = {mtvec_q[XLEN-1:2], 2'b00};

  assign bus.csr_rdata      = (!rst && bus.csr_valid && !illegal) ? old_val : '0;
  assign bus.redirect_valid = exc || mret_ev || irq_ev;
  assign bus.trap_taken     = exc || irq_ev;

  always_comb begin
    bus.redirect_pc = '0;
    if (exc) begin
      bus.redirect_pc = tvec_base;
    end else if (mret_ev) begin
      bus.redirect_pc = mepc_q;
    end else if (irq_ev) begin
      // Vectored mode only applies to interrupts
      bus.redirect_pc = mtvec_q[0] ? tvec_base + {{(XLEN-6){1'b0}}, irq_code, 2'b00}
                                   : tvec_base;
    end
  end

  always_comb begin
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (exc || irq_ev) begin
      mepc_d     = bus.pc & XLEN'(MEPC_WMASK);
      mcause_d   = exc ? {{(XLEN-4){1'b0}}, exc_cause}
                       : {1'b1, {(XLEN-5){1'b0}}, irq_code};
      mtval_d    = exc ? exc_tval : mtval_q;
      mst_mpie_d = mst_mie_q;
      mst_mie_d  = 1'b0;
    end else if (mret_ev) begin
      mst_mie_d  = mst_mpie_q;
      mst_mpie_d = 1'b1;
    end else if (csr_wr) begin
      case (bus.csr_addr)
        CSR_MSTATUS: begin
          mst_mie_d  = new_val[MSTATUS_MIE_BIT];
          mst_mpie_d = new_val[MSTATUS_MPIE_BIT];
        end
        CSR_MIE:      mie_d      = new_val & XLEN'(MIE_WMASK);
        CSR_MTVEC:    mtvec_d    = new_val & XLEN'(MTVEC_WMASK);
        CSR_MSCRATCH: mscratch_d = new_val;
        CSR_MEPC:     mepc_d     = new_val & XLEN'(MEPC_WMASK);
        CSR_MCAUSE:   mcause_d   = new_val;
        CSR_MTVAL:    mtval_d    = new_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mst_mie_q  <= MSTATUS_RESET[MSTATUS_MIE_BIT];
      mst_mpie_q <= MSTATUS_RESET[MSTATUS_MPIE_BIT];
      mie_q      <= '0;
      mtvec_q    <= XLEN'(MTVEC_RESET & MTVEC_WMASK);
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
    end
  end

  // Counter writes replace only the low XLEN bits
  assign cyc_we = csr_wr && (bus.csr_addr == CSR_MCYCLE);
  assign ins_we = csr_wr && (bus.csr_addr == CSR_MINSTRET);
  always_comb begin
    cyc_wdata = mcycle;
    cyc_wdata[XLEN-1:0] = new_val;
    ins_wdata = minstret;
    ins_wdata[XLEN-1:0] = new_val;
  end

  if (HAS_COUNTERS) begin : g_counters
    csr_counter u_mcycle (
      .clk(clk), .rst(rst), .inc_i(1'b1), .we_i(cyc_we),
      .wdata_i(cyc_wdata), .count_o(mcycle)
    );
    csr_counter u_minstret (
      .clk(clk), .rst(rst), .inc_i(bus.retire), .we_i(ins_we),
      .wdata_i(ins_wdata), .count_o(minstret)
    );
  end else begin : g_no_counters
    assign mcycle   = '0;
    assign minstret = '0;
  end
endmodule

// File: tb/tb_csr_unit.sv
// tb_csr_unit: directed and randomized checks of csr_unit against a
// behavioural model held as an address-indexed CSR table with write masks.
module tb_csr_unit;
  localparam int          XLEN     = 64;
  localparam logic [63:0] MST_RST  = 64'h0000_000a_0000_1800;
  localparam logic [63:0] HARTID_V = 64'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [63:0] m_csr   [logic [11:0]];
  logic [63:0] m_wmask [logic [11:0]];

  logic [63:0] s_rdata, s_rpc;
  logic        s_rv, s_tt;

  csr_unit_if #(.XLEN(XLEN)) bus ();

  csr_unit #(
    .XLEN(XLEN), .MSTATUS_RESET(MST_RST), .MTVEC_RESET(64'h0),
    .HARTID(HARTID_V), .HAS_COUNTERS(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_csr.delete();
    m_csr[12'h300] = MST_RST;
    m_csr[12'h301] = 64'h8000_0000_0000_1100;
    m_csr[12'h304] = 64'h0;
    m_csr[12'h305] = 64'h0;
    m_csr[12'h340] = 64'h0;
    m_csr[12'h341] = 64'h0;
    m_csr[12'h342] = 64'h0;
    m_csr[12'h343] = 64'h0;
    m_csr[12'hB00] = 64'h0;
    m_csr[12'hB02] = 64'h0;
    m_csr[12'hF14] = HARTID_V;
  endfunction

  function automatic logic [63:0] m_read(input logic [11:0] a, input logic [63:0] mip);
    if (a == 12'h344) return mip;
    if (a == 12'hC00) return m_csr[12'hB00];
    if (a == 12'hC02) return m_csr[12'hB02];
    return m_csr[a];
  endfunction

  // ---------------- model + compare, every cycle ----------------
  always @(negedge clk) begin : compare
    logic [11:0] a;
    logic [63:0] mip, old, opnd, nv, mst, pend, base, exp_pc;
    bit legal, ro, wr, illegal, exc, take;
    int code;
    if (rst) begin
      check("rst_rdata", bus.csr_rdata, 64'h0);
      check("rst_redirect_valid", {63'd0, bus.redirect_valid}, 64'h0);
      check("rst_trap_taken", {63'd0, bus.trap_taken}, 64'h0);
      model_reset();
    end else begin
      a = bus.csr_addr;
      mip = 64'h0;
      mip[11] = bus.meip;
      mip[7]  = bus.mtip;
      mip[3]  = bus.msip;
      legal = m_csr.exists(a) || a == 12'h344 || a == 12'hC00 || a == 12'hC02;
      ro = (a[11:10] == 2'b11) || a == 12'h344;
      wr = (bus.csr_op[1:0] == 2'b01) || (bus.csr_rs1 != 5'd0);
      illegal = bus.csr_valid && (!legal || (ro && wr));
      old = legal ? m_read(a, mip) : 64'h0;
      opnd = bus.csr_op[2] ? {59'd0, bus.csr_rs1} : bus.csr_rs1data;
      case (bus.csr_op[1:0])
        2'b01:   nv = opnd;
        2'b10:   nv = old | opnd;
        default: nv = old & ~opnd;
      endcase
      check("rdata", bus.csr_rdata, (bus.csr_valid && !illegal) ? old : 64'h0);

      exc  = illegal || bus.ecall || bus.ebreak;
      mst  = m_csr[12'h300];
      pend = m_csr[12'h304] & mip;
      take = !exc && !bus.mret && bus.irq_window && mst[3] && (pend != 64'h0);
      code = pend[11] ? 11 : (pend[3] ? 3 : 7);
      base = m_csr[12'h305] & ~64'h3;
      check("redirect_valid", {63'd0, bus.redirect_valid}, {63'd0, exc || bus.mret || take});
      check("trap_taken", {63'd0, bus.trap_taken}, {63'd0, exc || take});
      if (exc || bus.mret || take) begin
        if (exc)           exp_pc = base;
        else if (bus.mret) exp_pc = m_csr[12'h341];
        else               exp_pc = m_csr[12'h305][0] ? base + 64'(4 * code) : base;
        check("redirect_pc", bus.redirect_pc, exp_pc);
      end

      // state update for the coming clock edge
      m_csr[12'hB00] = m_csr[12'hB00] + 64'd1;
      if (bus.retire) m_csr[12'hB02] = m_csr[12'hB02] + 64'd1;
      if (exc || take) begin
        m_csr[12'h341] = bus.pc & ~64'h3;
        if (exc) begin
          m_csr[12'h342] = illegal ? 64'd2 : (bus.ecall ? 64'd11 : 64'd3);
          m_csr[12'h343] = illegal ? {52'd0, a} : (bus.ecall ? 64'h0 : bus.pc);
        end else begin
          m_csr[12'h342] = (64'd1 << 63) | 64'(code);
        end
        mst[7] = mst[3];
        mst[3] = 1'b0;
        m_csr[12'h300] = mst;
      end else if (bus.mret) begin
        mst[3] = mst[7];
        mst[7] = 1'b1;
        m_csr[12'h300] = mst;
      end else if (bus.csr_valid && wr) begin
        m_csr[a] = (m_csr[a] & ~m_wmask[a]) | (nv & m_wmask[a]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_clear();
    bus.csr_valid = 1'b0; bus.csr_op = 3'b000; bus.csr_addr = 12'h0;
    bus.csr_rs1 = 5'd0; bus.csr_rs1data = 64'h0;
    bus.ecall = 1'b0; bus.ebreak = 1'b0; bus.mret = 1'b0; bus.pc = 64'h0;
    bus.irq_window = 1'b0; bus.retire = 1'b0;
    bus.meip = 1'b0; bus.msip = 1'b0; bus.mtip = 1'b0;
  endtask

  task automatic sample_and_step();
    @(negedge clk);
    s_rdata = bus.csr_rdata;
    s_rv    = bus.redirect_valid;
    s_rpc   = bus.redirect_pc;
    s_tt    = bus.trap_taken;
    @(posedge clk);
    #1;
    drive_clear();
  endtask

  task automatic idle();
    drive_clear();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_req(input logic [2:0] op, input logic [11:0] a, input logic [4:0] rs1,
                         input logic [63:0] d);
    bus.csr_valid = 1'b1; bus.csr_op = op; bus.csr_addr = a;
    bus.csr_rs1 = rs1; bus.csr_rs1data = d;
    sample_and_step();
  endtask

  task automatic sys_req(input int kind, input logic [63:0] p);
    bus.pc = p;
    bus.ecall = (kind == 0); bus.ebreak = (kind == 1); bus.mret = (kind == 2);
    sample_and_step();
  endtask

  task automatic irq_req(input logic ei, input logic si, input logic ti, input logic [63:0] p);
    bus.pc = p; bus.irq_window = 1'b1;
    bus.meip = ei; bus.msip = si; bus.mtip = ti;
    sample_and_step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] c0;
    logic [2:0]  ops [6];
    logic [11:0] addrs [19];
    int k;
    ops = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
    addrs = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
              12'h344, 12'hB00, 12'hB02, 12'hC00, 12'hC02, 12'hF14,
              12'h7C0, 12'h000, 12'h345, 12'hB01, 12'hF15};
    m_wmask[12'h300] = 64'h88;   m_wmask[12'h301] = 64'h0;
    m_wmask[12'h304] = 64'h888;  m_wmask[12'h305] = ~64'h2;
    m_wmask[12'h340] = ~64'h0;   m_wmask[12'h341] = ~64'h3;
    m_wmask[12'h342] = ~64'h0;   m_wmask[12'h343] = ~64'h0;
    m_wmask[12'hB00] = ~64'h0;   m_wmask[12'hB02] = ~64'h0;
    m_wmask[12'hF14] = 64'h0;
    model_reset();

    // reset: a request during reset reads 0
    drive_clear();
    rst = 1'b1;
    bus.csr_valid = 1'b1; bus.csr_op = 3'b010; bus.csr_addr = 12'h300;
    @(negedge clk);
    check("reset_rdata", bus.csr_rdata, 64'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    drive_clear();
    rst = 1'b0;

    csr_req(3'b010, 12'h300, 5'd0, 64'h0);
    check("mstatus_reset", s_rdata, 64'ha00001800);
    csr_req(3'b010, 12'hB00, 5'd0, 64'h0);
    c0 = s_rdata;
    csr_req(3'b010, 12'hB00, 5'd0, 64'h0);
    check("mcycle_step", s_rdata, c0 + 64'd1);

    csr_req(3'b001, 12'h305, 5'd1, 64'h80000103);
    csr_req(3'b010, 12'h305, 5'd0, 64'h0);
    check("mtvec_mask", s_rdata, 64'h80000101);
    csr_req(3'b001, 12'h341, 5'd1, 64'h80000007);
    csr_req(3'b010, 12'h341, 5'd0, 64'h0);
    check("mepc_mask", s_rdata, 64'h80000004);

    // ecall / mret
    csr_req(3'b110, 12'h300, 5'd8, 64'h0);
    csr_req(3'b001, 12'h305, 5'd1, 64'h80001000);
    sys_req(0, 64'h80000010);
    check("ecall_rv", {63'd0, s_rv}, 64'h1);
    check("ecall_rpc", s_rpc, 64'h80001000);
    check("ecall_tt", {63'd0, s_tt}, 64'h1);
    csr_req(3'b010, 12'h341, 5'd0, 64'h0);
    check("ecall_mepc", s_rdata, 64'h80000010);
    csr_req(3'b010, 12'h342, 5'd0, 64'h0);
    check("ecall_mcause", s_rdata, 64'd11);
    csr_req(3'b010, 12'h300, 5'd0, 64'h0);
    check("ecall_mstatus", s_rdata, 64'ha00001880);
    sys_req(2, 64'h80000020);
    check("mret_rpc", s_rpc, 64'h80000010);
    check("mret_tt", {63'd0, s_tt}, 64'h0);
    csr_req(3'b010, 12'h300, 5'd0, 64'h0);
    check("mret_mstatus", s_rdata, 64'ha00001888);

    // vectored interrupts
    csr_req(3'b001, 12'h305, 5'd1, 64'h80001001);
    csr_req(3'b001, 12'h304, 5'd1, 64'h80);
    irq_req(1'b0, 1'b0, 1'b1, 64'h80000040);
    check("mti_rpc", s_rpc, 64'h8000101C);
    check("mti_tt", {63'd0, s_tt}, 64'h1);
    csr_req(3'b010, 12'h342, 5'd0, 64'h0);
    check("mti_mcause", s_rdata, 64'h8000000000000007);
    sys_req(2, 64'h80000044);
    csr_req(3'b001, 12'h304, 5'd1, 64'h880);
    irq_req(1'b1, 1'b0, 1'b1, 64'h80000048);
    check("mei_rpc", s_rpc, 64'h8000102C);
    csr_req(3'b010, 12'h342, 5'd0, 64'h0);
    check("mei_mcause", s_rdata, 64'h800000000000000B);

    // illegal CSR accesses
    csr_req(3'b001, 12'hF14, 5'd1, 64'h1234);
    check("ill_ro_tt", {63'd0, s_tt}, 64'h1);
    check("ill_ro_rpc", s_rpc, 64'h80001000);
    csr_req(3'b010, 12'h342, 5'd0, 64'h0);
    check("ill_mcause", s_rdata, 64'd2);
    csr_req(3'b010, 12'h343, 5'd0, 64'h0);
    check("ill_ro_mtval", s_rdata, 64'hF14);
    csr_req(3'b001, 12'h7C0, 5'd1, 64'h1234);
    csr_req(3'b010, 12'h343, 5'd0, 64'h0);
    check("ill_addr_mtval", s_rdata, 64'h7C0);
    csr_req(3'b010, 12'hF14, 5'd0, 64'h0);
    check("hartid_read", s_rdata, HARTID_V);
    check("hartid_no_trap", {63'd0, s_rv}, 64'h0);

    // counters
    csr_req(3'b001, 12'hB00, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    idle();
    csr_req(3'b010, 12'hB00, 5'd0, 64'h0);
    check("mcycle_wrap", s_rdata, 64'h0);
    bus.retire = 1'b1;
    csr_req(3'b001, 12'hB02, 5'd1, 64'd5);
    csr_req(3'b010, 12'hB02, 5'd0, 64'h0);
    check("minstret_write_wins", s_rdata, 64'd5);

    // randomized traffic, model checked every cycle
    for (int n = 0; n < 4000; n++) begin
      drive_clear();
      bus.meip = ($urandom_range(0, 3) == 0);
      bus.msip = ($urandom_range(0, 3) == 0);
      bus.mtip = ($urandom_range(0, 3) == 0);
      bus.irq_window = ($urandom_range(0, 2) == 0);
      bus.retire = $urandom_range(0, 1);
      bus.pc = {32'd0, $urandom} & ~64'h3;
      k = $urandom_range(0, 19);
      if (k < 13) begin
        bus.csr_valid = 1'b1;
        bus.csr_op = ops[$urandom_range(0, 5)];
        bus.csr_addr = ($urandom_range(0, 9) == 0) ? addrs[$urandom_range(14, 18)]
                                                   : addrs[$urandom_range(0, 13)];
        bus.csr_rs1 = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bus.csr_rs1data = {$urandom, $urandom};
      end else if (k == 13) begin
        bus.ecall = 1'b1;
      end else if (k == 14) begin
        bus.ebreak = 1'b1;
      end else if (k <= 16) begin
        bus.mret = 1'b1;
      end
      rst = ($urandom_range(0, 399) == 0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Machine-mode CSR file and trap controller for the RV64 core, replacing the fixed four-entry CSR array kept inside the decode stage.
- Executes the six Zicsr ops, ECALL/EBREAK/MRET, illegal-CSR traps and three machine interrupts.
- Adds mtvec vectored mode, mcycle/minstret counters and parametrised reset values.
- Sits beside ID/EX; the pipeline presents one system/CSR request per cycle at most and flushes on redirect.

Parameters:
XLEN, 64, datapath width (32 or 64); counters always 64-bit, upper half dropped when XLEN=32
MSTATUS_RESET, 64'h0000000a00001800, mstatus reset value; MPP field forced to 2'b11
MTVEC_RESET, 64'h0, mtvec reset value
HARTID, 0, value returned by mhartid
HAS_COUNTERS, 1, 0 removes mcycle/minstret; their addresses then become illegal

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
csr_valid  in  1  CSR instruction present this cycle
csr_op  in  3  funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI)
csr_addr  in  12  inst[31:20]
csr_rs1  in  5  rs1 index, also used as zimm
csr_rs1data  in  XLEN  rs1 register value
csr_rdata  out  XLEN  old CSR value for rd (combinational)
ecall  in  1  ECALL at pc
ebreak  in  1  EBREAK at pc
mret  in  1  MRET at pc
pc  in  XLEN  pc of the current system instruction
irq_window  in  1  instruction boundary where an interrupt may be taken
retire  in  1  one instruction retired this cycle
meip, msip, mtip  in  1 each  level-sensitive interrupt lines
redirect_valid  out  1  flush and fetch from redirect_pc (combinational)
redirect_pc  out  XLEN  trap vector or mepc
trap_taken  out  1  a trap or interrupt is committed this cycle

Behaviour:
- Implemented CSRs: mstatus 300, misa 301, mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342, mtval 343, mip 344, mcycle B00, minstret B02, cycle C00, instret C02, mhartid F14. Any other address is illegal.
- Operand is csr_rs1data when csr_op[2]=0, otherwise the zero-extended csr_rs1 (zimm).
- New value: RW = operand; RS = old | operand; RC = old & ~operand.
- RS/RC/RSI/RCI with csr_rs1=0 perform no write, so they are legal on read-only CSRs.
- Read-only CSRs are addr[11:10]=2'b11 plus mip. misa ignores writes.
- Write masks:
  - mstatus: only MIE[3], MPIE[7] writable; all other bits hold their reset values.
  - mie: bits 3, 7, 11 writable.
  - mepc: bits [1:0] forced to 0.
  - mtvec: bit 1 forced to 0.
- mip reads {meip<<11 | mtip<<7 | msip<<3}.
- Read latency 0: csr_rdata shows the pre-write value. Writes are visible from the next cycle. csr_rdata is 0 when there is no valid legal request.
- Illegal CSR (bad address, or a real write to a read-only CSR): no CSR write; trap with cause 2, mtval = {inst bits unavailable} = csr_addr zero-extended.
- Trap entry (ecall cause 11, ebreak cause 3 with mtval=pc, illegal cause 2):
  - mepc<=pc, mcause<=cause, MPIE<=MIE, MIE<=0.
  - redirect_pc = {mtvec[XLEN-1:2],2'b00}.
- MRET: MIE<=MPIE, MPIE<=1; redirect_pc=mepc; trap_taken=0.
- Interrupt taken when irq_window & MIE & (mie & mip)!=0 and no ecall/ebreak/mret/illegal in the same cycle.
  - Priority: MEI(11) > MSI(3) > MTI(7).
  - mcause = {1,code}; mepc<=pc; same mstatus update as trap entry.
  - A CSR request in the same cycle is squashed (no write).
  - Vectored mode (mtvec[0]=1): redirect_pc = base + 4*code. Exceptions always go to base.
- Event priority: rst > exception (illegal/ecall/ebreak) > mret > interrupt > CSR write.
- Counters:
  - mcycle increments every cycle; minstret increments on retire.
  - A CSR write to a counter in the same cycle wins over its increment.
  - Counters wrap from all-ones to 0.
- Reset:
  - mstatus=MSTATUS_RESET, mtvec=MTVEC_RESET; mie, mscratch, mepc, mcause, mtval, counters = 0.
  - Outputs read 0 / deasserted while rst=1.
  - Reset during any event discards that event.

Decomposition:
- Shared package csr_pkg holds:
  - CSR address constants
  - csr_op encodings
  - cause codes (2, 3, 11; interrupt codes 3, 7, 11)
  - mstatus/mie bit positions
  - write masks
- Sub-module csr_counter: 64-bit counter with increment enable, write-enable/data override, synchronous reset; instantiated twice, generated only when HAS_COUNTERS=1.

Test Plan:
- Reset, then CSRRS x5, mstatus, x0 -> csr_rdata=64'ha00001800, no write; next cycle mcycle reads 1 more than the previous sample.
- CSRRW mtvec with rs1data=64'h80000103 -> reads back 64'h80000101. CSRRW mepc 64'h80000007 -> reads 64'h80000004.
- ecall at pc=64'h80000010 with MIE=1, mtvec=64'h80001000 -> redirect_pc=64'h80001000, mepc=64'h80000010, mcause=11, MIE=0, MPIE=1; then mret -> redirect_pc=64'h80000010, MIE=1.
- mtvec=64'h80001001, mie bit 7 set, MIE=1, mtip=1, irq_window=1 -> mcause=64'h8000000000000007, redirect_pc=64'h8000101C. Same stimulus with meip also set -> cause 11, pc 64'h8000102C.
- CSRRW to mhartid (F14) or to address 7C0 -> no write, cause 2, mtval=64'hF14 / 64'h7C0. CSRRS mhartid with rs1=0 -> legal, reads HARTID.
- Write mcycle=64'hFFFFFFFFFFFFFFFF, then idle one cycle -> reads 0. Write minstret=5 together with retire=1 -> reads 5.
